// File: rtl/gpu_vf_pkg.sv
// Shared types and helpers for the batch vertex fetcher.
// Used by vertex_fetch_batch and its stall-counter build variant (VF_STALL_CNT_EN).
package gpu_vf_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} vf_state_t;

  // Byte stride of one vertex: attrs * attr_width bits.
  function automatic logic [31:0] vf_stride(input logic [31:0] attrs,
                                            input logic [31:0] attr_width);
    return (attrs * attr_width) >> 3;
  endfunction

  function automatic logic vf_lane_en(input logic [31:0] lane,
                                      input logic [31:0] attr_cnt);
    return lane < attr_cnt;
  endfunction

endpackage

// File: rtl/vf_fifo.sv
// Synchronous FIFO with combinational read of the head entry.
// A push while full is taken only when a pop frees the slot in the same cycle.
module vf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vertex_fetch_batch.sv
// Batch vertex fetcher: one start fetches N vertices, buffers them, streams them out.
// Define VF_STALL_CNT_EN to add the o_stall_cycles performance counter.
module vertex_fetch_batch
  import gpu_vf_pkg::*;
#(
  parameter int ATTR_WIDTH  = 32,
  parameter int MAX_ATTRS   = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-1:0]           i_base_addr,
  input  logic [COUNT_WIDTH-1:0]          i_first_index,
  input  logic [COUNT_WIDTH-1:0]          i_vertex_count,
  input  logic [$clog2(MAX_ATTRS):0]      i_attr_count,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_mem_req,
  output logic [ADDR_WIDTH-1:0]           o_mem_addr,
  input  logic                            i_mem_ready,
  input  logic [ATTR_WIDTH*MAX_ATTRS-1:0] i_mem_rdata,
  output logic                            o_vtx_valid,
  input  logic                            i_vtx_ready,
  output logic [ATTR_WIDTH*MAX_ATTRS-1:0] o_vtx_data,
  output logic                            o_vtx_last
`ifdef VF_STALL_CNT_EN
  ,
  output logic [31:0]                     o_stall_cycles
`endif
);
  localparam int BUS = ATTR_WIDTH * MAX_ATTRS;
  localparam int ACW = $clog2(MAX_ATTRS) + 1;

  vf_state_t              state;
  logic [ADDR_WIDTH-1:0]  base_q, stride_q, start_stride;
  logic [COUNT_WIDTH-1:0] idx_q, idx_nxt, k_q, count_q;
  logic [ACW-1:0]         attr_q, attr_clamp;
  logic                   fifo_full, fifo_empty, pop, accept, last_req;
  logic [BUS:0]           push_data, pop_data;

  function automatic logic [ADDR_WIDTH-1:0] vtx_addr(input logic [ADDR_WIDTH-1:0]  b,
                                                     input logic [COUNT_WIDTH-1:0] idx,
                                                     input logic [ADDR_WIDTH-1:0]  s);
    return b + ADDR_WIDTH'(idx) * s;
  endfunction

  assign attr_clamp   = (i_attr_count == '0 || i_attr_count > ACW'(MAX_ATTRS)) ?
                        ACW'(MAX_ATTRS) : i_attr_count;
  assign start_stride = ADDR_WIDTH'(vf_stride(32'(attr_clamp), 32'(ATTR_WIDTH)));
  assign idx_nxt      = idx_q + COUNT_WIDTH'(1);
  assign last_req     = (k_q == count_q - COUNT_WIDTH'(1));

  // A same-cycle pop frees a slot, so a full FIFO can still take a beat.
  assign pop       = o_vtx_valid & i_vtx_ready;
  assign o_mem_req = (state == FETCH) & (~fifo_full | pop);
  assign accept    = o_mem_req & i_mem_ready;

  for (genvar l = 0; l < MAX_ATTRS; l++) begin : g_lane
    assign push_data[l*ATTR_WIDTH +: ATTR_WIDTH] =
      vf_lane_en(32'(l), 32'(attr_q)) ? i_mem_rdata[l*ATTR_WIDTH +: ATTR_WIDTH] : '0;
  end
  assign push_data[BUS] = last_req;

  vf_fifo #(.WIDTH(BUS + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (push_data),
    .pop   (pop),
    .rdata (pop_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Gate with valid so stale/unwritten storage never reaches the outputs.
  assign o_vtx_valid = ~fifo_empty;
  assign o_vtx_data  = o_vtx_valid ? pop_data[BUS-1:0] : '0;
  assign o_vtx_last  = o_vtx_valid & pop_data[BUS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_mem_addr <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      idx_q      <= '0;
      k_q        <= '0;
      count_q    <= '0;
      attr_q     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          base_q     <= i_base_addr;
          stride_q   <= start_stride;
          idx_q      <= i_first_index;
          k_q        <= '0;
          count_q    <= i_vertex_count;
          attr_q     <= attr_clamp;
          o_mem_addr <= vtx_addr(i_base_addr, i_first_index, start_stride);
          if (i_vertex_count != '0) begin
            state  <= FETCH;
            o_busy <= 1'b1;
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        FETCH: if (accept) begin
          k_q        <= k_q + COUNT_WIDTH'(1);
          idx_q      <= idx_nxt;
          o_mem_addr <= vtx_addr(base_q, idx_nxt, stride_q);
          if (last_req) state <= DRAIN;
        end
        DRAIN: if (fifo_empty) begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VF_STALL_CNT_EN
  // Any FETCH cycle without an accepted beat is a stall (memory busy or FIFO full).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_stall_cycles <= '0;
    else if (state == IDLE && i_start)
      o_stall_cycles <= '0;
    else if (state == FETCH && !accept && o_stall_cycles != '1)
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vertex_fetch_batch.sv
// Directed bench for vertex_fetch_batch; memory returns address-tagged lanes.
module tb_vertex_fetch_batch;
  localparam int BUS = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [31:0]      i_base_addr;
  logic [15:0]      i_first_index, i_vertex_count;
  logic [3:0]       i_attr_count;
  logic             o_busy, o_done, o_mem_req, i_mem_ready;
  logic [31:0]      o_mem_addr;
  logic [BUS-1:0]   i_mem_rdata, o_vtx_data;
  logic             o_vtx_valid, i_vtx_ready, o_vtx_last;
`ifdef VF_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, last_acc_cyc = 0;
  logic [31:0]    acc_q[$];
  logic [BUS-1:0] dat_q[$];
  logic           lst_q[$];

  always #5 clk = ~clk;

  vertex_fetch_batch dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_base_addr    (i_base_addr),
    .i_first_index  (i_first_index),
    .i_vertex_count (i_vertex_count),
    .i_attr_count   (i_attr_count),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ready    (i_mem_ready),
    .i_mem_rdata    (i_mem_rdata),
    .o_vtx_valid    (o_vtx_valid),
    .i_vtx_ready    (i_vtx_ready),
    .o_vtx_data     (o_vtx_data),
    .o_vtx_last     (o_vtx_last)
`ifdef VF_STALL_CNT_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  // Memory model: lane j = {j+1, addr[23:0]}
  always_comb begin
    i_mem_rdata = '0;
    for (int j = 0; j < 8; j++) i_mem_rdata[j*32 +: 32] = {8'(j + 1), o_mem_addr[23:0]};
  end

  function automatic logic [BUS-1:0] exp_vtx(input logic [31:0] a, input int n);
    logic [BUS-1:0] d = '0;
    for (int j = 0; j < 8; j++) if (j < n) d[j*32 +: 32] = {8'(j + 1), a[23:0]};
    return d;
  endfunction

  // Monitor samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (o_mem_req && i_mem_ready) begin
        acc_q.push_back(o_mem_addr);
        last_acc_cyc = cyc;
      end
      if (o_vtx_valid && i_vtx_ready) begin
        dat_q.push_back(o_vtx_data);
        lst_q.push_back(o_vtx_last);
      end
      if (o_done) done_cnt++;
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [BUS-1:0] obs, input logic [BUS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    acc_q.delete();
    dat_q.delete();
    lst_q.delete();
  endtask

  task automatic start_batch(input logic [31:0] b, input logic [15:0] f,
                             input logic [15:0] c, input logic [3:0] a);
    i_base_addr = b; i_first_index = f; i_vertex_count = c; i_attr_count = a;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int maxc);
    int n = 0;
    while (done_cnt == d0 && n < maxc) begin
      step(1);
      n++;
    end
    chk("done_timeout", done_cnt != d0, 1);
  endtask

  task automatic check_batch(input string tag, input logic [31:0] b, input logic [15:0] f,
                             input int count, input int attrs);
    logic [31:0] a;
    logic [15:0] idx;
    chk($sformatf("%s_nreq", tag), acc_q.size(), count);
    chk($sformatf("%s_nout", tag), dat_q.size(), count);
    for (int k = 0; k < count; k++) begin
      idx = f + 16'(k);
      a   = b + 32'(idx) * 32'(attrs * 4);
      if (k < acc_q.size()) chk($sformatf("%s_addr%0d", tag, k), acc_q[k], a);
      if (k < dat_q.size()) begin
        chk($sformatf("%s_data%0d", tag, k), dat_q[k], exp_vtx(a, attrs));
        chk($sformatf("%s_last%0d", tag, k), lst_q[k], k == count - 1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  o_busy,      0);
    chk({tag, "_done"},  o_done,      0);
    chk({tag, "_req"},   o_mem_req,   0);
    chk({tag, "_addr"},  o_mem_addr,  0);
    chk({tag, "_valid"}, o_vtx_valid, 0);
    chk({tag, "_last"},  o_vtx_last,  0);
    chk({tag, "_data"},  o_vtx_data,  0);
  endtask

  initial begin
    int d0, f0, n;
    rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_first_index = '0;
    i_vertex_count = '0; i_attr_count = '0; i_mem_ready = 1'b1; i_vtx_ready = 1'b1;
    step(2);
    chk_all_zero("reset");
`ifdef VF_STALL_CNT_EN
    chk("reset_stall", stall_cycles, 0);
`endif
    rst = 1'b0;
    step(1);

    // Basic batch: 3 vertices, 8 attrs, stride 32
    clear_q(); d0 = done_cnt;
    start_batch(32'h1000, 16'd2, 16'd3, 4'd8);
    chk("t1_busy", o_busy, 1);
    chk("t1_req_lat", o_mem_req, 1);
    chk("t1_addr0", o_mem_addr, 32'h1040);
    chk("t1_valid_early", o_vtx_valid, 0);
    step(1);
    chk("t1_valid_lat", o_vtx_valid, 1);
    chk("t1_head", o_vtx_data, exp_vtx(32'h1040, 8));
    wait_done(d0, 50);
    step(3);
    chk("t1_one_done", done_cnt, d0 + 1);
    chk("t1_idle_busy", o_busy, 0);
    check_batch("t1", 32'h1000, 16'd2, 3, 8);

    // 4 attrs: stride 16, upper lanes zero
    clear_q(); d0 = done_cnt;
    start_batch(32'h2000, 16'd0, 16'd2, 4'd4);
    wait_done(d0, 50);
    step(2);
    check_batch("t2", 32'h2000, 16'd0, 2, 4);
    if (dat_q.size() > 1) chk("t2_upper_zero", dat_q[1][255:128], 0);

    // Zero-length batch
    clear_q(); d0 = done_cnt;
    start_batch(32'h4000, 16'd5, 16'd0, 4'd8);
    chk("t3_done", o_done, 1);
    chk("t3_busy", o_busy, 0);
    chk("t3_req", o_mem_req, 0);
    step(1);
    chk("t3_done_drop", o_done, 0);
    step(2);
    chk("t3_nreq", acc_q.size(), 0);
    chk("t3_one_done", done_cnt, d0 + 1);

    // Back-pressure: FIFO fills after 4; attr_count 0 clamps to 8
    clear_q(); d0 = done_cnt;
    i_vtx_ready = 1'b0;
    start_batch(32'h0, 16'd0, 16'd8, 4'd0);
    step(10);
    chk("t4_nacc_full", acc_q.size(), 4);
    chk("t4_req_low", o_mem_req, 0);
    chk("t4_valid", o_vtx_valid, 1);
    chk("t4_hold_data", o_vtx_data, exp_vtx(32'h0, 8));
    chk("t4_hold_last", o_vtx_last, 0);
    i_vtx_ready = 1'b1;
    wait_done(d0, 100);
    step(2);
    check_batch("t4", 32'h0, 16'd0, 8, 8);

    // Random memory ready, index wrap, ignored mid-batch start
    clear_q(); d0 = done_cnt;
    start_batch(32'h3000, 16'hFFFE, 16'd4, 4'd2);
    f0 = cyc;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      i_mem_ready = 1'($urandom_range(0, 1));
      if (n == 2) begin
        i_base_addr = 32'h9000; i_first_index = 16'd1; i_vertex_count = 16'd5;
        i_attr_count = 4'd8; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step(1);
      n++;
    end
    i_start = 1'b0; i_mem_ready = 1'b1;
    chk("t5_timeout", done_cnt != d0, 1);
    step(3);
    chk("t5_one_done", done_cnt, d0 + 1);
    check_batch("t5", 32'h3000, 16'hFFFE, 4, 2);
`ifdef VF_STALL_CNT_EN
    chk("t5_stall", stall_cycles, last_acc_cyc - f0 + 1 - 4);
    step(3);
    chk("t5_stall_hold", stall_cycles, last_acc_cyc - f0 + 1 - 4);
`endif

    // Reset during FETCH with 2 entries buffered
    clear_q(); d0 = done_cnt;
    i_vtx_ready = 1'b0;
    start_batch(32'h1000, 16'd2, 16'd8, 4'd8);
    step(2);
    chk("t6_nacc", acc_q.size(), 2);
    chk("t6_valid_pre", o_vtx_valid, 1);
    i_mem_ready = 1'b0;
    rst = 1'b1;
    step(1);
    chk_all_zero("t6_rst");
    rst = 1'b0; i_mem_ready = 1'b1; i_vtx_ready = 1'b1;
    step(2);
    chk("t6_no_done", done_cnt, d0);
    clear_q();
    start_batch(32'h1000, 16'd2, 16'd3, 4'd8);
    wait_done(d0, 50);
    step(2);
    check_batch("t6_after", 32'h1000, 16'd2, 3, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
